// File: rtl/mips16_pkg.sv
`default_nettype none
// =============================================================================
// Package : mips16_pkg
// Brief   : Shared widths, flag indices and the result-stage entry type.
// Rev     : 1.0
// =============================================================================
package mips16_pkg;

  localparam int DATA_W  = 16;
  localparam int FLAGS_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic [DATA_W-1:0]  result;
    logic [FLAGS_W-1:0] flags;
  } alu_entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_stage_skid_buffer2.sv
`default_nettype none
// =============================================================================
// Module : skid_buffer2
// Brief  : Generic 2-entry valid/ready buffer with registered ready and flush.
// Rev    : 1.0
// =============================================================================
module skid_buffer2
  import mips16_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  buf_state_t       r_state;
  buf_state_t       w_state_next;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_skid;

  logic w_push;
  logic w_pop;
  logic w_load_out_in;
  logic w_load_out_skid;
  logic w_load_skid;

  assign w_push = in_valid && r_in_ready;
  assign w_pop  = r_out_valid && out_ready;

  always_comb begin
    w_state_next    = r_state;
    w_load_out_in   = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    if (flush) begin
      // a concurrent input is dropped; a concurrent pop has already been taken
      w_state_next = BUF_EMPTY;
    end else begin
      unique case (r_state)
        BUF_EMPTY: begin
          if (w_push) begin
            w_state_next  = BUF_ONE;
            w_load_out_in = 1'b1;
          end
        end
        BUF_ONE: begin
          if (w_push && w_pop) begin
            w_load_out_in = 1'b1;
          end else if (w_push) begin
            w_state_next = BUF_FULL;
            w_load_skid  = 1'b1;
          end else if (w_pop) begin
            w_state_next = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (w_pop) begin
            w_state_next    = BUF_ONE;
            w_load_out_skid = 1'b1;
          end
        end
        default: w_state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= BUF_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_skid      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next != BUF_FULL);
      r_out_valid <= (w_state_next != BUF_EMPTY);
      if (w_load_out_in)
        r_out <= in_data;
      else if (w_load_out_skid)
        r_out <= r_skid;
      if (w_load_skid)
        r_skid <= in_data;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out;

endmodule
`default_nettype wire

// File: rtl/alu_result_stage.sv
`default_nettype none
// =============================================================================
// Module : alu_result_stage
// Brief  : Execute-stage output register deriving Z/N/C/V behind a 2-deep skid
//          buffer. Define ALU_RESULT_PARITY_EN to add the out_parity output.
// Rev    : 1.0
// =============================================================================
module alu_result_stage
  import mips16_pkg::*;
#(
  parameter int DATA_W = mips16_pkg::DATA_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Aa,
  input  logic [DATA_W-1:0] Bb,
  input  logic              add_sub_sel,
  input  logic [DATA_W-1:0] sum,
  input  logic              carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [3:0]        out_flags
`ifdef ALU_RESULT_PARITY_EN
  ,
  output logic              out_parity
`endif
);

  // the buffer implements exactly two entries whatever DEPTH says
  localparam int c_unused_depth = DEPTH;

  alu_entry_t w_entry;
  alu_entry_t w_out_entry;
  logic       w_msb_a;
  logic       w_msb_b;
  logic       w_msb_s;
  logic       w_unused_ops;

  assign w_msb_a      = Aa[DATA_W-1];
  assign w_msb_b      = Bb[DATA_W-1];
  assign w_msb_s      = sum[DATA_W-1];
  assign w_unused_ops = ^{Aa[DATA_W-2:0], Bb[DATA_W-2:0]};

  always_comb begin
    w_entry                = '0;
    w_entry.result         = sum;
    w_entry.flags[FLAG_Z]  = (sum == '0);
    w_entry.flags[FLAG_N]  = w_msb_s;
    w_entry.flags[FLAG_C]  = carry;
    // subtract overflows when operand signs differ, add when they match
    if (add_sub_sel)
      w_entry.flags[FLAG_V] = (w_msb_a != w_msb_b) && (w_msb_s != w_msb_a);
    else
      w_entry.flags[FLAG_V] = (w_msb_a == w_msb_b) && (w_msb_s != w_msb_a);
  end

`ifdef ALU_RESULT_PARITY_EN
  localparam int c_payload_w = $bits(alu_entry_t) + 1;
  logic [c_payload_w-1:0] w_in_payload;
  logic [c_payload_w-1:0] w_out_payload;
  assign w_in_payload              = {w_entry, ^sum};
  assign {w_out_entry, out_parity} = w_out_payload;
`else
  localparam int c_payload_w = $bits(alu_entry_t);
  logic [c_payload_w-1:0] w_in_payload;
  logic [c_payload_w-1:0] w_out_payload;
  assign w_in_payload = w_entry;
  assign w_out_entry  = w_out_payload;
`endif

  skid_buffer2 #(
    .WIDTH (c_payload_w)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (w_in_payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_payload)
  );

  assign out_result = w_out_entry.result;
  assign out_flags  = w_out_entry.flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_stage.sv
`default_nettype none
// =============================================================================
// Module : tb_alu_result_stage
// Brief  : Self-checking bench: directed vector table, handshake corner
//          sequences and randomized traffic against a queue-based model.
// Rev    : 1.0
// =============================================================================
module tb_alu_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] Aa;
  logic [15:0] Bb;
  logic        add_sub_sel;
  logic [15:0] sum;
  logic        carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_flags;
`ifdef ALU_RESULT_PARITY_EN
  logic        out_parity;
`endif

  always #5 clk = ~clk;

  alu_result_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .Aa          (Aa),
    .Bb          (Bb),
    .add_sub_sel (add_sub_sel),
    .sum         (sum),
    .carry       (carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags)
`ifdef ALU_RESULT_PARITY_EN
    ,
    .out_parity  (out_parity)
`endif
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sel;
    logic [15:0] sum;
    logic        carry;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  flags;
  } ent_t;

  ent_t model_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: flags from plain integer arithmetic (signed range for V).
  function automatic vec_t ref_vec(input logic [15:0] a, input logic [15:0] b, input logic sel);
    vec_t r;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ur = sel ? ua - ub : ua + ub;
    sr = sel ? sa - sb : sa + sb;
    r.a     = a;
    r.b     = b;
    r.sel   = sel;
    r.sum   = ur[15:0];
    r.carry = sel ? (ua >= ub) : (ur > 65535);
    r.flags = {r.sum == 16'h0000, r.sum >= 16'h8000, r.carry, (sr > 32767) || (sr < -32768)};
    return r;
  endfunction

  task automatic check_outputs(input bit after_reset);
    chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, model_q.size() < 2});
    if (model_q.size() > 0) begin
      chk("out_result", {16'd0, out_result}, {16'd0, model_q[0].result});
      chk("out_flags",  {28'd0, out_flags},  {28'd0, model_q[0].flags});
`ifdef ALU_RESULT_PARITY_EN
      chk("out_parity", {31'd0, out_parity}, {31'd0, ^model_q[0].result});
`endif
    end
    if (after_reset) begin
      chk("reset_result", {16'd0, out_result}, 32'd0);
      chk("reset_flags",  {28'd0, out_flags},  32'd0);
    end
  endtask

  // Drive one cycle, advance the model at the edge, check #1 later.
  task automatic cycle(input bit v, input vec_t d, input bit ordy, input bit fl, input bit rs);
    bit exp_push, exp_pop;
    exp_push    = v && (model_q.size() < 2);
    exp_pop     = (model_q.size() > 0) && ordy;
    in_valid    = v;
    Aa          = d.a;
    Bb          = d.b;
    add_sub_sel = d.sel;
    sum         = d.sum;
    carry       = d.carry;
    out_ready   = ordy;
    flush       = fl;
    rst         = rs;
    @(posedge clk);
    if (rs || fl) begin
      model_q.delete();
    end else begin
      if (exp_pop) void'(model_q.pop_front());
      if (exp_push) model_q.push_back('{d.sum, d.flags});
    end
    #1;
    check_outputs(rs);
  endtask

  vec_t vecs[9];
  vec_t idle;
  vec_t vx, vy, vz, vw;

  initial begin
    // {a, b, sel, sum, carry, expected {Z,N,C,V}}
    vecs[0] = '{16'h0010, 16'h0002, 1'b0, 16'h0012, 1'b0, 4'b0000};
    vecs[1] = '{16'h0010, 16'h0010, 1'b1, 16'h0000, 1'b1, 4'b1010};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 4'b0101};
    vecs[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 4'b0011};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 4'b1010};
    vecs[5] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 4'b0100};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 4'b1011};
    vecs[7] = '{16'h0004, 16'h0003, 1'b0, 16'h0007, 1'b0, 4'b0000};
    vecs[8] = '{16'h0005, 16'h0002, 1'b1, 16'h0003, 1'b1, 4'b0010};
    idle    = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 4'b0000};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    Aa = '0; Bb = '0; add_sub_sel = 1'b0; sum = '0; carry = 1'b0;
    cycle(0, idle, 1, 0, 1);
    cycle(0, idle, 1, 0, 1);
    cycle(0, idle, 1, 0, 0);

    // directed table: one-cycle latency, then drained
    for (int i = 0; i < 9; i++) begin
      cycle(1, vecs[i], 1, 0, 0);
      cycle(0, idle,    1, 0, 0);
    end

    // backpressure: third input stalls, all three drain in order
    vx = ref_vec(16'h1234, 16'h0101, 1'b0);
    vy = ref_vec(16'h0003, 16'h0009, 1'b1);
    vz = ref_vec(16'h4000, 16'h4000, 1'b0);
    cycle(1, vx, 0, 0, 0);
    cycle(1, vy, 0, 0, 0);
    cycle(1, vz, 0, 0, 0);
    cycle(1, vz, 0, 0, 0);
    cycle(1, vz, 1, 0, 0);
    cycle(1, vz, 1, 0, 0);
    cycle(0, idle, 1, 0, 0);
    cycle(0, idle, 1, 0, 0);

    // flush while full, with a concurrent input that must be dropped
    vw = ref_vec(16'hAAAA, 16'h5555, 1'b1);
    cycle(1, vx, 0, 0, 0);
    cycle(1, vy, 0, 0, 0);
    cycle(1, vw, 0, 1, 0);
    cycle(0, idle, 1, 0, 0);
    // flush while ONE with a concurrent input and pop
    cycle(1, vx, 0, 0, 0);
    cycle(1, vw, 1, 1, 0);
    cycle(1, vz, 1, 0, 0);
    cycle(0, idle, 1, 0, 0);

    // reset while full, flush also high: reset wins, everything cleared
    cycle(1, vx, 0, 0, 0);
    cycle(1, vy, 0, 0, 0);
    cycle(0, idle, 0, 1, 1);
    cycle(0, idle, 1, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      vec_t rv;
      case ($urandom_range(0, 4))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      case ($urandom_range(0, 4))
        0:       rb = 16'hFFFF;
        1:       rb = ra;
        default: rb = 16'($urandom);
      endcase
      rv = ref_vec(ra, rb, 1'($urandom_range(0, 1)));
      cycle(($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 39) == 0), 1'b0);
    end
    cycle(0, idle, 1, 0, 0);
    cycle(0, idle, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Execute-stage output register that consumes the 16-bit add/subtract unit's sum/carry and the operands that produced them.
- Derives Z/N/C/V flags and registers result plus flags behind a valid/ready handshake.
- Holds a 2-entry skid buffer so a memory/writeback stall never drops a result.
- Sits between the add/sub unit and the MEM/WB stage of the 16-bit MIPS datapath.

Parameters:
- DATA_W, 16, operand/result width.
- DEPTH, 2, skid buffer entries; only 2 is supported.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered results; synchronous.
- in_valid  in  1  sum/carry/operands valid this cycle.
- in_ready  out  1  stage can accept an entry.
- Aa  in  DATA_W  operand A as presented to the adder.
- Bb  in  DATA_W  operand B as presented to the adder.
- add_sub_sel  in  1  0 = add, 1 = subtract (A-B).
- sum  in  DATA_W  adder result.
- carry  in  1  adder carry-out (for subtract: 1 = no borrow).
- out_valid  out  1  out_result/out_flags valid.
- out_ready  in  1  downstream accepts.
- out_result  out  DATA_W  registered sum.
- out_flags  out  4  {Z,N,C,V}, bit3 = Z.

Behaviour:
- Reset: the clock is clk. Reset is synchronous and active-high (rst), sampled on the rising edge. On reset: out_valid=0, out_result=0, out_flags=0, buffer count=0, in_ready=1 in the following cycle.
- Flag rules, computed combinationally from the inputs and captured with the entry:
  - Z = (sum==0).
  - N = sum[DATA_W-1].
  - C = carry, passed raw.
  - V, add: Aa[msb]==Bb[msb] && sum[msb]!=Aa[msb].
  - V, sub: Aa[msb]!=Bb[msb] && sum[msb]!=Aa[msb].
- Transfers:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Latency: 1 cycle. An entry accepted in cycle n is on out_* in cycle n+1 when the buffer was empty.
- States by count:
  - EMPTY(0): in_ready=1, out_valid=0. Accept -> ONE.
  - ONE(1): in_ready=1, out_valid=1.
    - Accept and pop -> ONE; the new entry appears next cycle.
    - Accept only -> FULL; the second entry goes to the skid slot.
    - Pop only -> EMPTY.
  - FULL(2): in_ready=0, out_valid=1. Pop -> ONE; the skid entry moves to the output register in the same edge.
- in_ready is registered: it depends only on count, never combinationally on out_ready.
- Ordering is strict FIFO; no entry is duplicated or lost.
- out_result/out_flags hold stable while out_valid && !out_ready.
- Boundaries:
  - Reset while FULL clears both entries; the pending result is discarded.
  - flush in any state -> EMPTY next cycle. A simultaneous input transfer is discarded; a simultaneous pop still counts as consumed.
  - rst has priority over flush.
  - in_valid while FULL is ignored; upstream must hold its inputs.
  - Data registers are undefined-but-stable when out_valid=0. out_result/out_flags hold their last value.
- Width/arithmetic wrap, e.g. 16'hFFFF+1: sum=0, C=1, Z=1, V=0.

Optional Feature:
- Macro: ALU_RESULT_PARITY_EN.
- Defined: adds output out_parity (1 bit) = even parity (XOR) of out_result, registered with the entry and valid with out_valid.
- Undefined: the port and its logic are absent. Flags and all other behaviour are unchanged.

Decomposition:
- Shared package mips16_pkg:
  - DATA_W=16.
  - Flag index constants FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
  - Typedef for the {result, flags} entry.
- Sub-module skid_buffer2: a generic 2-entry valid/ready buffer carrying the entry payload, with flush.
- The flag derivation stays in the top module.

Test Plan:
- Add: Aa=16'h0010, Bb=16'h0002, sel=0, sum=16'h0012, carry=0 -> next cycle out_result=16'h0012, flags=4'b0000.
- Sub: Aa=16'h0010, Bb=16'h0010, sel=1, sum=0, carry=1 -> flags Z=1, C=1, N=0, V=0 (4'b1010).
- Overflow: add Aa=16'h7FFF, Bb=16'h0001, sum=16'h8000 -> N=1, V=1. Sub Aa=16'h8000, Bb=16'h0001, sum=16'h7FFF, carry=1 -> V=1, C=1.
- Backpressure: hold out_ready=0, issue 3 back-to-back inputs -> first two accepted, in_ready=0 after the second, third stalls. Release out_ready -> outputs appear in order, one per cycle, none lost.
- Flush/reset: with the buffer FULL, assert flush for 1 cycle -> out_valid=0 and in_ready=1 next cycle. Repeat with rst -> all outputs 0.
- With ALU_RESULT_PARITY_EN: result 16'h0007 -> out_parity=1; result 16'h0003 -> out_parity=0.
